// File: rtl/bsg_fsb_node_trace_loader.sv
// Loadable trace store: packs a narrow beat stream into trace entries for the FSB replay engine.
// Optional macro BSG_FSB_TRACE_LOADER_PAD_FINISH_EN: unwritten addresses read back as a finish op.
//
// state  | meaning
// eLoad  | accepting beats, packing entries into storage
// eReady | frozen, storage read-stable, waiting for restart_i
module bsg_fsb_node_trace_loader #(
  parameter int ring_width_p     = 80,
  parameter int rom_addr_width_p = 6,
  parameter int in_width_p       = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            v_i,
  input  logic [in_width_p-1:0]           data_i,
  input  logic                            last_i,
  output logic                            ready_o,
  input  logic                            restart_i,
  input  logic [rom_addr_width_p-1:0]     rom_addr_i,
  output logic [ring_width_p+4-1:0]       rom_data_o,
  output logic                            loaded_o,
  output logic                            full_o,
  output logic [rom_addr_width_p:0]       entries_o
);

  localparam int w_lp      = ring_width_p + 4;
  localparam int b_lp      = (w_lp + in_width_p - 1) / in_width_p;
  localparam int d_lp      = 1 << rom_addr_width_p;
  localparam int bcnt_w_lp = (b_lp > 1) ? $clog2(b_lp) : 1;
  localparam int asm_w_lp  = b_lp * in_width_p;

  typedef enum logic {eLoad, eReady} state_e;

  state_e                      state_q;
  logic [bcnt_w_lp-1:0]        bcnt_q;
  logic [rom_addr_width_p:0]   wp_q;
  logic [asm_w_lp-1:0]         asm_q;
  logic [asm_w_lp-1:0]         asm_next;
  logic [w_lp-1:0]             mem [d_lp];

  logic                        accept;
  logic                        last_beat;
  logic                        write_entry;
  logic                        at_top;
  logic [rom_addr_width_p-1:0] wr_addr;

  assign ready_o     = (state_q == eLoad) & reset_n_i;
  // Restart wins over a beat offered in the same cycle.
  assign accept      = v_i & ready_o & ~restart_i;
  assign last_beat   = (bcnt_q == bcnt_w_lp'(b_lp - 1));
  assign write_entry = accept & (last_beat | last_i);
  assign wr_addr     = wp_q[rom_addr_width_p-1:0];
  assign at_top      = (wr_addr == rom_addr_width_p'(d_lp - 1));
  assign entries_o   = wp_q;

  always_comb begin
    asm_next = asm_q;
    asm_next[int'(bcnt_q) * in_width_p +: in_width_p] = data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eLoad;
      bcnt_q   <= '0;
      wp_q     <= '0;
      asm_q    <= '0;
      loaded_o <= 1'b0;
      full_o   <= 1'b0;
      for (int i = 0; i < d_lp; i++) mem[i] <= '0;
    end else if (restart_i) begin
      state_q  <= eLoad;
      bcnt_q   <= '0;
      wp_q     <= '0;
      asm_q    <= '0;
      loaded_o <= 1'b0;
      full_o   <= 1'b0;
    end else if (accept) begin
      if (write_entry) begin
        // Bits of the final beat above the entry width fall off here.
        mem[wr_addr] <= asm_next[w_lp-1:0];
        wp_q         <= wp_q + 1'b1;
        bcnt_q       <= '0;
        asm_q        <= '0;
        if (last_i) begin
          state_q  <= eReady;
          loaded_o <= 1'b1;
        end else if (at_top) begin
          state_q  <= eReady;
          loaded_o <= 1'b1;
          full_o   <= 1'b1;
        end
      end else begin
        asm_q  <= asm_next;
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rom_data_o = mem[rom_addr_i];
`ifdef BSG_FSB_TRACE_LOADER_PAD_FINISH_EN
    if ({1'b0, rom_addr_i} >= wp_q) rom_data_o = {4'd4, {ring_width_p{1'b0}}};
`endif
  end

endmodule

// File: tb/tb_bsg_fsb_node_trace_loader.sv
// Directed bench for bsg_fsb_node_trace_loader with W=16, B=2, D=4.
module tb_bsg_fsb_node_trace_loader;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        v_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        last_i = 1'b0;
  logic        ready_o;
  logic        restart_i = 1'b0;
  logic [1:0]  rom_addr_i = '0;
  logic [15:0] rom_data_o;
  logic        loaded_o;
  logic        full_o;
  logic [2:0]  entries_o;

  int checks = 0;
  int passes = 0;

`ifdef BSG_FSB_TRACE_LOADER_PAD_FINISH_EN
  localparam logic [15:0] unwritten_c = 16'h4000;
  localparam bit pad_c = 1'b1;
`else
  localparam logic [15:0] unwritten_c = 16'h0000;
  localparam bit pad_c = 1'b0;
`endif

  bsg_fsb_node_trace_loader #(
    .ring_width_p(12), .rom_addr_width_p(2), .in_width_p(8)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
    .last_i(last_i), .ready_o(ready_o), .restart_i(restart_i),
    .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o), .loaded_o(loaded_o),
    .full_o(full_o), .entries_o(entries_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    rom_addr_i = addr;
    #1;
    check(tag, 32'(rom_data_o), 32'(exp));
  endtask

  // Present one beat for one clock edge, then leave inputs idle 1ns after the edge.
  task automatic beat(input logic [7:0] d, input logic l, input logic rs);
    v_i = 1'b1; data_i = d; last_i = l; restart_i = rs;
    @(posedge clk_i); #1;
    v_i = 1'b0; last_i = 1'b0; restart_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_ready", 32'(ready_o), 0);
    check("rst_entries", 32'(entries_o), 0);
    check("rst_loaded", 32'(loaded_o), 0);
    check("rst_full", 32'(full_o), 0);
    read_check("rst_mem0", 2'd0, 16'h0000);
    @(negedge clk_i); reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("post_rst_ready", 32'(ready_o), 1);

    // Test 1: two-beat entry terminated by last
    beat(8'h34, 1'b0, 1'b0);
    check("t1_entries_b0", 32'(entries_o), 0);
    check("t1_ready_b0", 32'(ready_o), 1);
    beat(8'h12, 1'b1, 1'b0);
    check("t1_entries", 32'(entries_o), 1);
    check("t1_loaded", 32'(loaded_o), 1);
    check("t1_ready", 32'(ready_o), 0);
    check("t1_full", 32'(full_o), 0);
    read_check("t1_mem0", 2'd0, 16'h1234);

    // Test 4: unwritten addresses
    read_check("t4_mem3", 2'd3, unwritten_c);
    read_check("t4_mem1", 2'd1, unwritten_c);

    // Test 5: restart with a concurrent beat
    beat(8'h55, 1'b0, 1'b1);
    check("t5_loaded", 32'(loaded_o), 0);
    check("t5_entries", 32'(entries_o), 0);
    check("t5_ready", 32'(ready_o), 1);
    read_check("t5_stale0", 2'd0, pad_c ? 16'h4000 : 16'h1234);

    // Test 2: full entry then a zero-padded partial entry
    beat(8'hAA, 1'b0, 1'b0);
    beat(8'h1B, 1'b0, 1'b0);
    check("t2_entries1", 32'(entries_o), 1);
    read_check("t2_mem0", 2'd0, 16'h1BAA);
    beat(8'hCC, 1'b1, 1'b0);
    check("t2_entries2", 32'(entries_o), 2);
    check("t2_loaded", 32'(loaded_o), 1);
    read_check("t2_mem1", 2'd1, 16'h00CC);
    read_check("t2_mem2", 2'd2, unwritten_c);

    // Test 3: fill all four entries without last
    @(negedge clk_i); restart_i = 1'b1;
    @(posedge clk_i); #1; restart_i = 1'b0;
    check("t3_restart_ready", 32'(ready_o), 1);
    for (int i = 1; i <= 8; i++) begin
      beat(8'(i), 1'b0, 1'b0);
      if (i == 6) check("t3_entries_mid", 32'(entries_o), 3);
      if (i == 6) check("t3_full_mid", 32'(full_o), 0);
    end
    check("t3_full", 32'(full_o), 1);
    check("t3_loaded", 32'(loaded_o), 1);
    check("t3_entries", 32'(entries_o), 4);
    check("t3_ready", 32'(ready_o), 0);
    read_check("t3_mem0", 2'd0, 16'h0201);
    read_check("t3_mem3", 2'd3, 16'h0807);
    beat(8'hEE, 1'b0, 1'b0);
    check("t3_9th_entries", 32'(entries_o), 4);
    read_check("t3_9th_mem0", 2'd0, 16'h0201);

    // Test 6: asynchronous reset mid-entry
    beat(8'h00, 1'b0, 1'b1);
    beat(8'h77, 1'b0, 1'b0);
    #1; reset_n_i = 1'b0;
    #1;
    check("t6_ready", 32'(ready_o), 0);
    check("t6_entries", 32'(entries_o), 0);
    check("t6_loaded", 32'(loaded_o), 0);
    read_check("t6_mem0", 2'd0, 16'h0000);
    #3; reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    beat(8'h9A, 1'b0, 1'b0);
    beat(8'hBC, 1'b1, 1'b0);
    check("t6_entries_after", 32'(entries_o), 1);
    read_check("t6_mem0_after", 2'd0, 16'hBC9A);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_node_trace_loader.md
# bsg_fsb_node_trace_loader

Loadable trace store placed directly upstream of the FSB node trace replay engine. Accepts a narrow valid/ready byte stream, packs beats into `{op[3:0], payload[ring_width_p-1:0]}` trace entries, and writes them into an internal register array. The replay engine reads that array through an asynchronous address/data port. `loaded_o` rises once the trace is complete and is intended to drive the replay engine's `en_i`. Tests can swap traces at runtime without recompiling a ROM.

## Interface
- `ring_width_p`, default 80: trace payload width; entry width W = ring_width_p+4.
- `rom_addr_width_p`, default 6: entry address width; depth D = 2^rom_addr_width_p.
- `in_width_p`, default 8: load-stream beat width; beats per entry B = ceil(W/in_width_p).
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `v_i`, in, 1: load beat valid.
- `data_i`, in, in_width_p: load beat.
- `last_i`, in, 1: beat is the final beat of the whole trace.
- `ready_o`, out, 1: loader can accept a beat.
- `restart_i`, in, 1: discard the stored trace and return to loading.
- `rom_addr_i`, in, rom_addr_width_p: read address from the replay engine.
- `rom_data_o`, out, W: asynchronous read data.
- `loaded_o`, out, 1: trace complete, store is read-stable.
- `full_o`, out, 1: loading stopped because D entries were written without `last_i`.
- `entries_o`, out, rom_addr_width_p+1: number of entries written.

## Operation
- States:
  - eLoad: accepting beats.
  - eReady: frozen, serving reads.
- Reset (async assert, sync use after deassert):
  - state = eLoad; beat counter = 0; write pointer = 0; `entries_o` = 0.
  - `loaded_o` = 0, `full_o` = 0.
  - Assembly register and all storage entries cleared to 0.
  - `ready_o` = 0 while `reset_n_i` is low.
- `ready_o` = (state == eLoad) & `reset_n_i`.
- A beat is accepted when `v_i & ready_o`.
- Packing:
  - Beat k (k = 0..B-1) fills entry bits [k*in_width_p +: in_width_p], LSB-first.
  - Bits of the final beat beyond W are dropped.
- Entry write: on acceptance of beat B-1, or of any beat with `last_i`=1:
  - The assembled entry is written to mem[wp], with unfilled bits zero.
  - wp increments and the beat counter returns to 0.
  - `entries_o` = wp after the increment.
- Transitions out of eLoad:
  - Accepted beat with `last_i`: go to eReady and set `loaded_o`. A partial entry is zero-padded and written.
  - Entry written to address D-1 without `last_i`: go to eReady and set `loaded_o` and `full_o`.
- eReady: `restart_i` clears wp, the beat counter, `entries_o`, `loaded_o` and `full_o`, then returns to eLoad. Storage is not cleared.
- `restart_i` in eLoad: the same clear occurs. A beat presented in that same cycle is not accepted, because restart has priority.
- Reads:
  - `rom_data_o` = mem[`rom_addr_i`], combinational.
  - Reads are legal in any state.
  - An address below `entries_o` returns the written entry.
  - For addresses at or above `entries_o`, see Configuration.
- `entries_o` never wraps: its maximum is D, and it is rom_addr_width_p+1 bits wide.

## Timing
- Beat accepted at edge t:
  - If it completes an entry, the entry is readable via `rom_data_o` from edge t onward, i.e. after t in the same cycle window.
  - `entries_o` updates at t.
- `loaded_o` and `full_o` rise at the edge that accepts the terminating beat.
- `ready_o` is low in the following cycle.
- `restart_i` sampled at edge t: `loaded_o`=0 and `ready_o`=1 after t.
- Stall: `v_i` low holds all state. There is no timeout.
- Reset asserted mid-load: everything returns to reset values immediately (asynchronously). The partial entry is lost.

## Configuration
- `BSG_FSB_TRACE_LOADER_PAD_FINISH_EN`:
  - Defined: reads at addresses ≥ `entries_o` return {4'd4, zeros}, a finish op. An under-filled trace therefore terminates the replay engine cleanly.
  - Undefined: reads at addresses ≥ `entries_o` return raw storage contents. After reset these are zeros, which the engine executes as nops; after a restart they are stale entries.

## Test plan
Use ring_width_p=12, in_width_p=8, rom_addr_width_p=2 (W=16, B=2, D=4).
1. Reset, then load beats 0x34, 0x12(`last_i`=1) -> mem[0]=0x1234, `entries_o`=1, `loaded_o`=1 the next cycle, `ready_o`=0, and `rom_addr_i`=0 reads 0x1234.
2. Load 0xAA, 0x1B, then 0xCC alone with `last_i`=1 -> mem[0]=0x1BAA, mem[1]=0x00CC, `entries_o`=2.
3. Load 8 beats with no `last_i` -> four entries written, `full_o`=1, `loaded_o`=1, and a 9th beat with `v_i` high is not accepted.
4. With the macro defined, after test 1, `rom_addr_i`=3 reads 0x4000. With the macro undefined, the same read returns 0x0000.
5. In eReady, assert `restart_i` together with `v_i` -> the beat is not accepted, `loaded_o`=0, `entries_o`=0 and `ready_o`=1 next cycle. A new load then overwrites mem[0].
6. Assert `reset_n_i` low for half a cycle between beat 0 and beat 1 -> `ready_o`=0 immediately and `entries_o`=0. After release, the next beat lands in the low byte of mem[0].
